// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state encoding, CTRL bit indices and register offsets
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;

  localparam int CTRL_ENC     = 0;
  localparam int CTRL_DEC     = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_BUSY    = 3;
  localparam int CTRL_IRQ_EN  = 4;
  localparam int CTRL_ABORT   = 5;
  localparam int CTRL_ERR     = 6;
  localparam int CTRL_ABORTED = 7;

  localparam logic [19:0] OFF_CTRL = 20'd0;
  localparam logic [19:0] OFF_NBLK = 20'd4;
  localparam logic [19:0] OFF_BASE = 20'd8;
  localparam logic [19:0] OFF_STAT = 20'd12;

endpackage

// File: rtl/aes_seq_regs.sv
// rtl/aes_seq_regs.sv - MMIO decode, RW/W1C register bank and readback mux
module aes_seq_regs #(
  parameter int          ADDR_W   = 10,
  parameter int          CNT_W    = 8,
  parameter logic [19:0] REG_BASE = 20'h4_1000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_addr_in,
  input  logic [31:0]       cpu_data_in,
  input  logic [3:0]        cpu_write_enable_in,
  output logic [31:0]       cpu_data_out,
  input  logic              busy,
  input  logic              set_done,
  input  logic              set_err,
  input  logic              set_aborted,
  input  logic              clr_flags,
  input  logic [CNT_W-1:0]  completed,
  output logic [CNT_W-1:0]  nblk,
  output logic [ADDR_W-1:0] base,
  output logic              irq_en,
  output logic              done_flag,
  output logic              enc_wr,
  output logic              dec_wr,
  output logic              abort_wr
);
  import aes_pkg::*;

  logic sel_ctrl, sel_nblk, sel_base, sel_stat;
  logic wr, ctrl_wr;
  logic err_flag, aborted_flag;
  logic unused_bits;

  assign sel_ctrl = cpu_addr_in[19:0] == REG_BASE + OFF_CTRL;
  assign sel_nblk = cpu_addr_in[19:0] == REG_BASE + OFF_NBLK;
  assign sel_base = cpu_addr_in[19:0] == REG_BASE + OFF_BASE;
  assign sel_stat = cpu_addr_in[19:0] == REG_BASE + OFF_STAT;

  assign wr       = cpu_write_enable_in[0];
  assign ctrl_wr  = wr & sel_ctrl;
  assign enc_wr   = ctrl_wr & cpu_data_in[CTRL_ENC];
  assign dec_wr   = ctrl_wr & cpu_data_in[CTRL_DEC];
  assign abort_wr = ctrl_wr & cpu_data_in[CTRL_ABORT];

  assign unused_bits = ^{cpu_addr_in[31:20], cpu_data_in, cpu_write_enable_in[3:1]};

  // Hardware set outranks both the run-start clear and a software W1C.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      nblk         <= '0;
      base         <= '0;
      irq_en       <= 1'b0;
      done_flag    <= 1'b0;
      err_flag     <= 1'b0;
      aborted_flag <= 1'b0;
    end else begin
      if (wr && sel_nblk && !busy) nblk <= cpu_data_in[CNT_W-1:0];
      if (wr && sel_base && !busy) base <= cpu_data_in[ADDR_W-1:0];
      if (ctrl_wr) irq_en <= cpu_data_in[CTRL_IRQ_EN];
      done_flag    <= set_done | (done_flag & ~clr_flags &
                      ~(ctrl_wr & cpu_data_in[CTRL_DONE]));
      err_flag     <= set_err | (err_flag & ~clr_flags &
                      ~(ctrl_wr & cpu_data_in[CTRL_ERR]));
      aborted_flag <= set_aborted | (aborted_flag & ~clr_flags &
                      ~(ctrl_wr & cpu_data_in[CTRL_ABORTED]));
    end
  end

  always_comb begin
    cpu_data_out = '0;
    if (sel_ctrl) begin
      cpu_data_out[CTRL_DONE]    = done_flag;
      cpu_data_out[CTRL_BUSY]    = busy;
      cpu_data_out[CTRL_IRQ_EN]  = irq_en;
      cpu_data_out[CTRL_ERR]     = err_flag;
      cpu_data_out[CTRL_ABORTED] = aborted_flag;
    end else if (sel_nblk) begin
      cpu_data_out[CNT_W-1:0] = nblk;
    end else if (sel_base) begin
      cpu_data_out[ADDR_W-1:0] = base;
    end else if (sel_stat) begin
      cpu_data_out[CNT_W-1:0] = completed;
    end
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - sequences the AES core over a run of consecutive buffer blocks
module aes_block_sequencer #(
  parameter int          ADDR_W    = 10,
  parameter int          BLK_WORDS = 4,
  parameter int          CNT_W     = 8,
  parameter logic [19:0] REG_BASE  = 20'h4_1000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_addr_in,
  input  logic [31:0]       cpu_data_in,
  input  logic [3:0]        cpu_write_enable_in,
  output logic [31:0]       cpu_data_out,
  output logic              core_start_out,
  output logic              core_decrypt_out,
  output logic [ADDR_W-1:0] core_base_out,
  input  logic              core_done_in,
  output logic              irq_out
);
  import aes_pkg::*;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BLK_WORDS);

  seq_state_t        state;
  logic [CNT_W-1:0]  remaining, completed, nblk;
  logic [ADDR_W-1:0] cur_addr, base;
  logic              mode, abort_pending;
  logic              busy, irq_en, done_flag;
  logic              enc_wr, dec_wr, abort_wr, trig_one;
  logic              set_done, set_err, set_aborted, clr_flags;

  assign busy             = state != IDLE;
  assign trig_one         = enc_wr ^ dec_wr;
  assign core_decrypt_out = mode;
  assign core_base_out    = cur_addr;
  assign irq_out          = done_flag & irq_en;

  aes_seq_regs #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .REG_BASE (REG_BASE)
  ) u_regs (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .cpu_addr_in         (cpu_addr_in),
    .cpu_data_in         (cpu_data_in),
    .cpu_write_enable_in (cpu_write_enable_in),
    .cpu_data_out        (cpu_data_out),
    .busy                (busy),
    .set_done            (set_done),
    .set_err             (set_err),
    .set_aborted         (set_aborted),
    .clr_flags           (clr_flags),
    .completed           (completed),
    .nblk                (nblk),
    .base                (base),
    .irq_en              (irq_en),
    .done_flag           (done_flag),
    .enc_wr              (enc_wr),
    .dec_wr              (dec_wr),
    .abort_wr            (abort_wr)
  );

  always_comb begin
    clr_flags   = (state == IDLE) && trig_one && (nblk != '0);
    set_err     = (state == IDLE) && enc_wr && dec_wr;
    set_done    = ((state == IDLE) && trig_one && (nblk == '0)) || (state == DONE);
    set_aborted = (state == WAIT) && core_done_in && (abort_pending || abort_wr);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      core_start_out <= 1'b0;
      mode           <= 1'b0;
      cur_addr       <= '0;
      remaining      <= '0;
      completed      <= '0;
      abort_pending  <= 1'b0;
    end else begin
      core_start_out <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_one && nblk != '0) begin
            mode           <= dec_wr;
            cur_addr       <= base;
            remaining      <= nblk;
            completed      <= '0;
            abort_pending  <= 1'b0;
            core_start_out <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort_wr) abort_pending <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (abort_wr) abort_pending <= 1'b1;
          if (core_done_in) begin
            completed <= completed + 1'b1;
            remaining <= remaining - 1'b1;
            cur_addr  <= cur_addr + STRIDE;
            // An abort lands only once the in-flight block has finished.
            if (abort_pending || abort_wr) begin
              abort_pending <= 1'b0;
              state         <= IDLE;
            end else if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end else begin
              core_start_out <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - randomized self-checking bench with a queue-based block model
module tb_aes_block_sequencer;

  localparam logic [19:0] RB = 20'h4_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  we;
  logic        resp_done = 1'b0, force_done = 1'b0;
  wire  [31:0] rdata;
  wire         start, dec, irq;
  wire  [9:0]  cbase;
  wire         done_in = resp_done | force_done;

  always #5 clk = ~clk;

  aes_block_sequencer dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .cpu_addr_in         (addr),
    .cpu_data_in         (wdata),
    .cpu_write_enable_in (we),
    .cpu_data_out        (rdata),
    .core_start_out      (start),
    .core_decrypt_out    (dec),
    .core_base_out       (cbase),
    .core_done_in        (done_in),
    .irq_out             (irq)
  );

  int n_chk = 0, n_pass = 0;
  logic [10:0] exp_q[$];
  int   n_starts = 0;
  int   done_delay = 5;
  logic blk_open = 1'b0;
  logic [9:0] last_base;
  logic last_mode;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic wr(input logic [19:0] off, input logic [31:0] d);
    @(negedge clk);
    addr  = {12'($urandom_range(0, 4095)), RB + off};
    wdata = d;
    we    = 4'b0001 | 4'($urandom_range(0, 15));
    @(negedge clk);
    we = 4'b0000;
  endtask

  task automatic rd(input logic [19:0] off, output logic [31:0] d);
    @(negedge clk);
    addr = {12'h0, RB + off};
    we   = 4'b0000;
    #1 d = rdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] v;
    int g;
    g = 0;
    rd(20'd0, v);
    while (v[3] && g < 400) begin
      rd(20'd0, v);
      g++;
    end
    chk(name, {31'b0, v[3]}, 32'd0);
  endtask

  // Every start must match the next expected block; addresses must hold until its done.
  always @(negedge clk) begin
    if (start === 1'b1) begin
      n_starts++;
      if (exp_q.size() == 0) chk("spurious_start", {31'b0, start}, 32'd0);
      else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("start_base", {22'b0, cbase}, {22'b0, e[9:0]});
        chk("start_mode", {31'b0, dec}, {31'b0, e[10]});
      end
      blk_open  = 1'b1;
      last_base = cbase;
      last_mode = dec;
    end else if (done_in && blk_open) begin
      chk("hold_base", {22'b0, cbase}, {22'b0, last_base});
      chk("hold_mode", {31'b0, dec}, {31'b0, last_mode});
      blk_open = 1'b0;
    end
  end

  // Core stand-in: answers each start with a done pulse after a delay.
  initial forever begin
    @(posedge clk);
    #1;
    while (start === 1'b1) begin
      repeat (done_delay == 0 ? $urandom_range(1, 6) : done_delay) @(posedge clk);
      #1 resp_done = 1'b1;
      @(posedge clk);
      #1 resp_done = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int target, g;
    int e_stat;
    logic e_done, e_err, e_ab;
    rst = 1'b1; addr = '0; wdata = '0; we = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_start", {31'b0, start}, 32'd0);
    rd(20'd0, v);  chk("rst_ctrl", v, 32'd0);
    rd(20'd4, v);  chk("rst_nblk", v, 32'd0);
    rd(20'd8, v);  chk("rst_base", v, 32'd0);
    rd(20'd12, v); chk("rst_stat", v, 32'd0);

    // Three encrypt blocks from 0x010 with interrupt enabled.
    wr(20'd4, 32'd3);
    wr(20'd8, 32'h10);
    exp_q.push_back({1'b0, 10'h010});
    exp_q.push_back({1'b0, 10'h014});
    exp_q.push_back({1'b0, 10'h018});
    wr(20'd0, 32'h11);
    chk("first_start_latency", {31'b0, start}, 32'd1);
    rd(20'd0, v); chk("run1_busy_ctrl", v, 32'h18);
    wait_idle("run1_idle");
    rd(20'd12, v); chk("run1_stat", v, 32'd3);
    rd(20'd0, v);  chk("run1_ctrl", v, 32'h14);
    chk("run1_irq", {31'b0, irq}, 32'd1);
    chk("run1_q_empty", exp_q.size(), 32'd0);
    rd(20'd16, v);    chk("unmapped_16", v, 32'd0);
    rd(20'h00100, v); chk("unmapped_100", v, 32'd0);
    wr(20'd0, 32'h04);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rd(20'd0, v); chk("ctrl_cleared", v, 32'd0);

    // Decrypt run wrapping the word address.
    wr(20'd8, 32'h3FC);
    wr(20'd4, 32'd2);
    exp_q.push_back({1'b1, 10'h3FC});
    exp_q.push_back({1'b1, 10'h000});
    wr(20'd0, 32'h02);
    wait_idle("run2_idle");
    rd(20'd12, v); chk("run2_stat", v, 32'd2);
    rd(20'd0, v);  chk("run2_ctrl", v, 32'h04);
    chk("run2_q_empty", exp_q.size(), 32'd0);

    // Both triggers -> error; then zero-length run.
    wr(20'd0, 32'h03);
    chk("err_no_start", {31'b0, start}, 32'd0);
    rd(20'd0, v); chk("err_ctrl", v, 32'h44);
    wr(20'd0, 32'h44);
    rd(20'd0, v); chk("err_cleared", v, 32'd0);
    wr(20'd4, 32'd0);
    wr(20'd0, 32'h01);
    chk("zero_no_start", {31'b0, start}, 32'd0);
    rd(20'd0, v);  chk("zero_ctrl", v, 32'h04);
    rd(20'd12, v); chk("zero_stat", v, 32'd2);

    // Abort during block 2; a mid-run NBLK write must be dropped.
    wr(20'd4, 32'd4);
    wr(20'd8, 32'h100);
    exp_q.push_back({1'b0, 10'h100});
    exp_q.push_back({1'b0, 10'h104});
    target = n_starts + 2;
    wr(20'd0, 32'h01);
    wr(20'd4, 32'd9);
    g = 0;
    while (n_starts < target && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("abort_reach_blk2", {31'b0, n_starts >= target}, 32'd1);
    wr(20'd0, 32'h20);
    wait_idle("abort_idle");
    rd(20'd12, v); chk("abort_stat", v, 32'd2);
    rd(20'd0, v);  chk("abort_ctrl", v, 32'h80);
    rd(20'd4, v);  chk("busy_nblk_kept", v, 32'd4);
    chk("abort_q_empty", exp_q.size(), 32'd0);
    @(negedge clk); force_done = 1'b1;
    @(negedge clk); force_done = 1'b0;
    repeat (3) @(negedge clk);
    rd(20'd12, v); chk("idle_done_stat", v, 32'd2);
    rd(20'd0, v);  chk("idle_done_ctrl", v, 32'h80);

    // Reset while waiting on the core.
    done_delay = 8;
    wr(20'd4, 32'd3);
    wr(20'd8, 32'h20);
    exp_q.push_back({1'b0, 10'h020});
    wr(20'd0, 32'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    blk_open = 1'b0;
    chk("midrst_start", {31'b0, start}, 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    rd(20'd0, v);  chk("midrst_ctrl", v, 32'd0);
    rd(20'd4, v);  chk("midrst_nblk", v, 32'd0);
    rd(20'd8, v);  chk("midrst_base", v, 32'd0);
    rd(20'd12, v); chk("midrst_stat", v, 32'd0);
    repeat (12) @(negedge clk);
    rd(20'd0, v); chk("midrst_late_done", v, 32'd0);
    chk("midrst_q_empty", exp_q.size(), 32'd0);

    // Randomized runs against the register-level model.
    done_delay = 0;
    e_done = 1'b0; e_err = 1'b0; e_ab = 1'b0; e_stat = 0;
    for (int r = 0; r < 24; r++) begin
      int n, b;
      logic m, ie, bad;
      n   = $urandom_range(0, 6);
      b   = $urandom_range(0, 1023);
      m   = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 4) == 0);
      wr(20'd4, 32'(n));
      wr(20'd8, 32'(b));
      if (bad) begin
        wr(20'd0, 32'h03 | (32'(ie) << 4));
        chk("rnd_err_no_start", {31'b0, start}, 32'd0);
        e_err = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) exp_q.push_back({m, 10'(b + 4 * i)});
        wr(20'd0, (m ? 32'h02 : 32'h01) | (32'(ie) << 4));
        chk("rnd_start_latency", {31'b0, start}, {31'b0, n > 0});
        e_done = 1'b1;
        if (n > 0) begin
          e_err = 1'b0; e_ab = 1'b0; e_stat = n;
        end
      end
      wait_idle("rnd_idle");
      rd(20'd12, v); chk("rnd_stat", v, 32'(e_stat));
      rd(20'd0, v);
      chk("rnd_ctrl", v, {24'b0, e_ab, e_err, 1'b0, ie, 1'b0, e_done, 2'b00});
      chk("rnd_irq", {31'b0, irq}, {31'b0, e_done & ie});
      chk("rnd_q_empty", exp_q.size(), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_block_sequencer.md
Name: aes_block_sequencer

Overview:
MMIO-programmable controller that sequences the AES core over a run of consecutive 128-bit blocks in the AES buffer RAM. The CPU programs mode, base word address and block count, then sets a start bit. The sequencer issues one start pulse per block, waits for the core's done pulse and advances the block address. It exposes registered status, a completed-block counter and an optional interrupt. It sits between the CPU MMIO bus and the AES core/buffer pair, replacing ad-hoc combinational control bits with registered state.

Parameters:
ADDR_W, 10, buffer RAM word-address width
BLK_WORDS, 4, 32-bit words per AES block (address stride)
CNT_W, 8, width of block count and completed-block counter
REG_BASE, 20'h4_1000, cpu_addr_in[19:0] of the CTRL register; NBLK = +4, BASE = +8, STAT = +12

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
cpu_addr_in  in  32  CPU byte address
cpu_data_in  in  32  CPU write data
cpu_write_enable_in  in  4  CPU byte write enables; a register write requires bit 0
cpu_data_out  out  32  register readback; 0 when no register is addressed
core_start_out  out  1  one-cycle pulse that starts one block
core_decrypt_out  out  1  1 = decrypt, 0 = encrypt; held stable for the whole run
core_base_out  out  ADDR_W  word address of the current block
core_done_in  in  1  one-cycle pulse when the core finishes a block
irq_out  out  1  level interrupt = done_flag & irq_en

Behaviour:
- Reset: state IDLE, all registers 0, core_start_out = 0, irq_out = 0, cpu_data_out is 0 for unmapped addresses.
- CTRL (REG_BASE) bit fields:
  - bit0 ENC and bit1 DEC are write-1 start triggers and read back as 0.
  - bit2 DONE is set by hardware and cleared by writing 1.
  - bit3 BUSY is read-only; it is 1 whenever state != IDLE.
  - bit4 IRQ_EN is read/write.
  - bit5 ABORT is write-1.
  - bit6 ERR is set by hardware and cleared by writing 1.
  - bit7 ABORTED is set by hardware and cleared by writing 1.
- NBLK (+4) holds [CNT_W-1:0] block count. BASE (+8) holds [ADDR_W-1:0] start word address. Both are read/write, and writes are ignored while BUSY.
- STAT (+12) is read-only: [CNT_W-1:0] completed-block count for the current or last run.
- Readback is combinational on cpu_addr_in[19:0]. Unused bits read as 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: a CTRL write with exactly one of ENC/DEC set and NBLK != 0 does the following:
    - latches mode from DEC;
    - sets cur_addr = BASE and remaining = NBLK;
    - clears the completed count, DONE, ERR and ABORTED;
    - moves to ISSUE.
  - IDLE, both ENC and DEC set: sets ERR and stays in IDLE.
  - IDLE, NBLK == 0 with a valid trigger: sets DONE immediately and stays in IDLE (zero-length run).
  - ISSUE: drives core_start_out = 1 for exactly this cycle, then moves to WAIT. The first pulse appears the cycle after the triggering write.
  - WAIT, on core_done_in:
    - completed count += 1, remaining -= 1;
    - cur_addr += BLK_WORDS, wrapping modulo 2^ADDR_W;
    - if remaining was 1, go to DONE; otherwise go to ISSUE.
  - DONE: sets DONE for one cycle, then returns to IDLE. BUSY falls on the same edge.
- core_done_in in any state other than WAIT is ignored.
- ABORT written in ISSUE or WAIT sets a pending abort. The in-flight block is always allowed to finish (core_done_in in WAIT). After that the FSM goes to IDLE with ABORTED = 1 and DONE = 0, and issues no further starts. If ABORT is written in ISSUE, that block's start pulse is still issued.
- ABORT in IDLE has no effect.
- ENC/DEC writes while BUSY are ignored. IRQ_EN writes are always accepted.
- Simultaneous hardware set and software W1C of DONE in the same cycle: the set wins.
- core_decrypt_out and core_base_out are registered and stable from ISSUE through the block's core_done_in.
- Reset mid-run returns to IDLE on the next edge with no start pulse.

Decomposition:
- Shared package aes_pkg:
  - state enum seq_state_t {IDLE, ISSUE, WAIT, DONE};
  - CTRL bit-index localparams (CTRL_ENC=0 … CTRL_ABORTED=7);
  - register offset localparams.
- One natural sub-module: aes_seq_regs. It holds MMIO decode, W1C/RW registers and readback, leaving the FSM and counters in the top module.

Test Plan:
- Reset → BUSY = 0, irq_out = 0, reads of CTRL/NBLK/BASE/STAT return 0.
- NBLK = 3, BASE = 0x010, write CTRL = 0x11 (ENC + IRQ_EN); core_done_in pulses 5 cycles after each start → three starts with core_base_out 0x010, 0x014, 0x018 and core_decrypt_out = 0. Afterwards STAT = 3, DONE = 1 and irq_out = 1. Writing CTRL = 0x04 clears irq_out.
- BASE = 0x3FC, NBLK = 2, DEC trigger → base outputs 0x3FC then 0x000; core_decrypt_out = 1 throughout.
- Write CTRL = 0x03 → ERR = 1, no start pulse, BUSY = 0. Separately, NBLK = 0 with a valid trigger → DONE = 1 with no start pulse.
- NBLK = 4, ABORT written during block 2 WAIT → exactly two start pulses, STAT = 2, ABORTED = 1, DONE = 0, BUSY = 0 after block 2's done.
- Mid-run, write NBLK = 9 and pulse core_done_in in IDLE after the run ends → NBLK readback unchanged and STAT unchanged. Asserting rst_in mid-WAIT → IDLE next cycle with all registers 0.
